// File: rtl/inventory_access_scheduler_pkg.sv
// Shared types for the inventory access scheduler: slot kinds and the queued fill record.
package inventory_sched_pkg;

  localparam int FILL_SID_W = 2;
  localparam int FILL_QTY_W = 32;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WRITE,
    SLOT_READ
  } slot_e;

  typedef struct packed {
    logic [FILL_SID_W-1:0] stock_id;
    logic [FILL_QTY_W-1:0] qty;
    logic                  side;
  } fill_t;

endpackage

// File: rtl/inventory_access_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the grant is consumed (advance).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    masked   = '0;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    pick = (masked != '0) ? masked : req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/inventory_access_scheduler.sv
// Single-port scheduler for the normalised-inventory store: arbitrated fills are queued
// and written one per cycle, reads bypass the queue unless a queued fill targets the same stock.
module inventory_access_scheduler
  import inventory_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int NUM_STOCKS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int FIFO_DEPTH   = 4,
  localparam int SID_W       = $clog2(NUM_STOCKS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_fill_valid,
  input  logic [NUM_REQ*SID_W-1:0]      i_fill_stock_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_fill_qty,
  input  logic [NUM_REQ-1:0]            i_fill_side,
  output logic [NUM_REQ-1:0]            o_fill_ready,
  input  logic                          i_rd_valid,
  input  logic [SID_W-1:0]              i_rd_stock_id,
  output logic                          o_rd_ready,
  output logic                          o_rd_valid,
  output logic [FP_WORD_SIZE-1:0]       o_rd_norm_inventory,
  output logic [SID_W-1:0]              o_inv_stock_id,
  output logic                          o_inv_execute_order,
  output logic [DATA_WIDTH-1:0]         o_inv_execute_order_quantity,
  output logic                          o_inv_execute_order_side,
  input  logic [FP_WORD_SIZE-1:0]       i_inv_norm_inventory
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  fill_t               mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occ;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                hazard;
  logic                rd_pending;
  logic [NUM_REQ-1:0]  grant;
  fill_t               push_data;
  fill_t               head;
  slot_e               slot;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .req     (i_fill_valid),
    .advance (push),
    .grant   (grant)
  );

  // Handshakes: a transfer happens in any cycle where valid && ready; ready may depend on valid,
  // and both readies are held low while reset is asserted.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign o_fill_ready = (i_reset_n && !full) ? grant : '0;
  assign push         = |(o_fill_ready & i_fill_valid);
  assign pop          = (slot == SLOT_WRITE);
  assign o_rd_ready   = i_reset_n && (slot == SLOT_READ);
  assign head         = mem[rd_ptr];

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        push_data.stock_id = i_fill_stock_id[i*SID_W +: SID_W];
        push_data.qty      = i_fill_qty[i*DATA_WIDTH +: DATA_WIDTH];
        push_data.side     = i_fill_side[i];
      end
    end
  end

  // A read must not overtake any queued fill for the same stock.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occ[i] && (mem[i].stock_id == i_rd_stock_id)) hazard = 1'b1;
    end
  end

  always_comb begin
    slot = SLOT_IDLE;
    if (full)                         slot = SLOT_WRITE;
    else if (i_rd_valid && !hazard)   slot = SLOT_READ;
    else if (!empty)                  slot = SLOT_WRITE;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (push) begin
        occ[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_pending                   <= 1'b0;
      o_rd_valid                   <= 1'b0;
      o_rd_norm_inventory          <= '0;
      o_inv_stock_id               <= '0;
      o_inv_execute_order          <= 1'b0;
      o_inv_execute_order_quantity <= '0;
      o_inv_execute_order_side     <= 1'b0;
    end else begin
      rd_pending <= (slot == SLOT_READ);
      o_rd_valid <= rd_pending;
      if (rd_pending) o_rd_norm_inventory <= i_inv_norm_inventory;
      case (slot)
        SLOT_WRITE: begin
          o_inv_stock_id               <= head.stock_id;
          o_inv_execute_order_quantity <= head.qty;
          o_inv_execute_order_side     <= head.side;
          o_inv_execute_order          <= 1'b1;
        end
        SLOT_READ: begin
          o_inv_stock_id      <= i_rd_stock_id;
          o_inv_execute_order <= 1'b0;
        end
        default: o_inv_execute_order <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_inventory_access_scheduler.sv
// Bench for inventory_access_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inventory_access_scheduler;

  localparam int NUM_REQ = 2;
  localparam int NSTK    = 4;
  localparam int DW      = 32;
  localparam int FPW     = 64;
  localparam int DEPTH   = 4;
  localparam int SW      = 2;
  localparam int FW      = SW + DW + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_REQ-1:0]      fill_valid = '0;
  logic [NUM_REQ*SW-1:0]   fill_sid = '0;
  logic [NUM_REQ*DW-1:0]   fill_qty = '0;
  logic [NUM_REQ-1:0]      fill_side = '0;
  logic [NUM_REQ-1:0]      fill_ready;
  logic                    rd_valid = 1'b0;
  logic [SW-1:0]           rd_sid = '0;
  logic                    rd_ready;
  logic                    rd_out_valid;
  logic [FPW-1:0]          rd_data;
  logic [SW-1:0]           inv_sid;
  logic                    inv_exec;
  logic [DW-1:0]           inv_qty;
  logic                    inv_side;
  logic signed [FPW-1:0]   inv_out;

  // Environment store (driven only by DUT outputs) and the model's own copy.
  logic signed [FPW-1:0]   store  [NSTK];
  logic signed [FPW-1:0]   mstore [NSTK];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [FW-1:0]         exp_q[$];
  int                    rr = 0;
  logic [SW-1:0]         e_sid = '0;
  logic                  e_exec = 1'b0;
  logic [DW-1:0]         e_qty = '0;
  logic                  e_side = 1'b0;
  logic                  e_pend = 1'b0;
  logic                  e_rv = 1'b0;
  logic signed [FPW-1:0] e_rdata = '0;

  inventory_access_scheduler dut (
    .i_clk                        (clk),
    .i_reset_n                    (rst_n),
    .i_fill_valid                 (fill_valid),
    .i_fill_stock_id              (fill_sid),
    .i_fill_qty                   (fill_qty),
    .i_fill_side                  (fill_side),
    .o_fill_ready                 (fill_ready),
    .i_rd_valid                   (rd_valid),
    .i_rd_stock_id                (rd_sid),
    .o_rd_ready                   (rd_ready),
    .o_rd_valid                   (rd_out_valid),
    .o_rd_norm_inventory          (rd_data),
    .o_inv_stock_id               (inv_sid),
    .o_inv_execute_order          (inv_exec),
    .o_inv_execute_order_quantity (inv_qty),
    .o_inv_execute_order_side     (inv_side),
    .i_inv_norm_inventory         (inv_out)
  );

  // ---------------- clock / reset / store ----------------
  always #5 clk = ~clk;

  assign inv_out = store[inv_sid];

  initial begin
    for (int i = 0; i < NSTK; i++) begin
      store[i]  = 64'(1000 * (i + 1));
      mstore[i] = 64'(1000 * (i + 1));
    end
  end

  always @(posedge clk) begin
    if (inv_exec) begin
      store[inv_sid] <= inv_side ? store[inv_sid] - $signed({32'd0, inv_qty})
                                 : store[inv_sid] + $signed({32'd0, inv_qty});
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NUM_REQ-1:0]    x_ready;
    logic                  x_rd_ready;
    logic                  full;
    logic                  hazard;
    logic [FW-1:0]         h;
    logic signed [FPW-1:0] n_rdata;
    int                    g;
    int                    slot;
    g = -1;
    slot = 0;
    full = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      rr = 0; e_sid = '0; e_exec = 1'b0; e_qty = '0; e_side = 1'b0;
      e_pend = 1'b0; e_rv = 1'b0; e_rdata = '0;
      x_ready = '0; x_rd_ready = 1'b0;
    end else begin
      full = (exp_q.size() == DEPTH);
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (rr + k) % NUM_REQ;
        if (g < 0 && ((fill_valid >> idx) & 1) != 0) g = idx;
      end
      x_ready = (g >= 0 && !full) ? (NUM_REQ'(1) << g) : '0;
      hazard = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][FW-1 -: SW] == rd_sid) hazard = 1'b1;
      if (full)                        slot = 1;
      else if (rd_valid && !hazard)    slot = 2;
      else if (exp_q.size() > 0)       slot = 1;
      x_rd_ready = (slot == 2);
    end

    chk("fill_ready", 64'(fill_ready), 64'(x_ready));
    chk("rd_ready",   64'(rd_ready),   64'(x_rd_ready));
    chk("inv_exec",   64'(inv_exec),   64'(e_exec));
    chk("inv_sid",    64'(inv_sid),    64'(e_sid));
    chk("inv_qty",    64'(inv_qty),    64'(e_qty));
    chk("inv_side",   64'(inv_side),   64'(e_side));
    chk("rd_valid",   64'(rd_out_valid), 64'(e_rv));
    chk("rd_data",    rd_data,         e_rdata);

    if (rst_n) begin
      n_rdata = e_pend ? mstore[e_sid] : e_rdata;
      e_rv    = e_pend;
      e_rdata = n_rdata;
      if (e_exec) begin
        mstore[e_sid] = e_side ? mstore[e_sid] - $signed({32'd0, e_qty})
                               : mstore[e_sid] + $signed({32'd0, e_qty});
      end
      case (slot)
        1: begin
          h = exp_q.pop_front();
          e_sid = h[FW-1 -: SW]; e_qty = h[DW:1]; e_side = h[0];
          e_exec = 1'b1; e_pend = 1'b0;
        end
        2: begin
          e_sid = rd_sid; e_exec = 1'b0; e_pend = 1'b1;
        end
        default: begin
          e_exec = 1'b0; e_pend = 1'b0;
        end
      endcase
      if (g >= 0 && !full) begin
        exp_q.push_back({SW'(fill_sid >> (g * SW)), DW'(fill_qty >> (g * DW)),
                         1'((fill_side >> g) & 1)});
        rr = (g + 1) % NUM_REQ;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input int r, input int s, input int q, input bit sd);
    fill_valid[r]          = 1'b1;
    fill_sid[r*SW +: SW]   = SW'(s);
    fill_qty[r*DW +: DW]   = DW'(q);
    fill_side[r]           = sd;
  endtask

  task automatic drain();
    fill_valid = '0;
    rd_valid   = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic signed [FPW-1:0] base;

    // Reset state; readies stay low under reset even with requests present.
    repeat (2) tick();
    set_fill(0, 1, 5, 0);
    rd_valid = 1'b1;
    #1;
    chk("rst_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_rd_ready",   64'(rd_ready),   64'd0);
    chk("rst_inv_exec",   64'(inv_exec),   64'd0);
    chk("rst_rd_data",    rd_data,         64'd0);
    fill_valid = '0;
    rd_valid   = 1'b0;
    tick();
    rst_n = 1'b1;
    drain();

    // Single fill: stock 2, qty 100, sell.
    set_fill(0, 2, 100, 1);
    #1 chk("single_ready", 64'(fill_ready), 64'h1);
    tick();
    fill_valid = '0;
    tick();
    chk("single_exec", 64'(inv_exec), 64'd1);
    chk("single_sid",  64'(inv_sid),  64'd2);
    chk("single_qty",  64'(inv_qty),  64'd100);
    chk("single_side", 64'(inv_side), 64'd1);
    tick();
    chk("single_once", 64'(inv_exec), 64'd0);
    drain();

    // Round-robin from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drain();
    for (int c = 0; c < 4; c++) begin
      set_fill(0, 0, 10 + c, 0);
      set_fill(1, 1, 20 + c, 0);
      #1 chk("rr_grant", 64'(fill_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    #1 chk("rr_wrap", 64'(fill_ready), 64'h1);
    drain();

    // Read-after-fill hazard on stock 1.
    base = store[1];
    set_fill(0, 1, 50, 0);
    tick();
    fill_valid = '0;
    rd_valid   = 1'b1;
    rd_sid     = 2'd1;
    #1 chk("haz_stall", 64'(rd_ready), 64'd0);
    tick();
    #1 chk("haz_accept", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    tick();
    chk("haz_rvalid", 64'(rd_out_valid), 64'd1);
    chk("haz_data",   rd_data, base + 64'sd50);
    drain();

    // Read priority over two queued fills for stock 0.
    rd_valid = 1'b1;
    rd_sid   = 2'd3;
    set_fill(0, 0, 7, 0);
    tick();
    set_fill(0, 0, 8, 1);
    tick();
    fill_valid = '0;
    #1 chk("prio_accept", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    chk("prio_no_write", 64'(inv_exec), 64'd0);
    tick();
    chk("prio_rvalid", 64'(rd_out_valid), 64'd1);
    chk("prio_w1_exec", 64'(inv_exec), 64'd1);
    chk("prio_w1_qty",  64'(inv_qty),  64'd7);
    tick();
    chk("prio_w2_qty",  64'(inv_qty),  64'd8);
    chk("prio_w2_side", 64'(inv_side), 64'd1);
    drain();

    // Full FIFO forces a write and refuses the requester.
    rd_valid = 1'b1;
    rd_sid   = 2'd3;
    for (int c = 0; c < 4; c++) begin
      set_fill(0, 0, 30 + c, 0);
      tick();
    end
    #1;
    chk("full_fill_ready", 64'(fill_ready), 64'd0);
    chk("full_rd_ready",   64'(rd_ready),   64'd0);
    tick();
    fill_valid = '0;
    #1 chk("full_then_read", 64'(rd_ready), 64'd1);
    drain();

    // Async reset with queued fills and a read in flight.
    rd_valid = 1'b1;
    rd_sid   = 2'd3;
    for (int c = 0; c < 3; c++) begin
      set_fill(0, 0, 40 + c, 1);
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("areset_exec",   64'(inv_exec),     64'd0);
    chk("areset_sid",    64'(inv_sid),      64'd0);
    chk("areset_qty",    64'(inv_qty),      64'd0);
    chk("areset_rvalid", 64'(rd_out_valid), 64'd0);
    chk("areset_data",   rd_data,           64'd0);
    chk("areset_ready",  64'(fill_ready),   64'd0);
    fill_valid = '0;
    rd_valid   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("post_rst_exec",   64'(inv_exec),     64'd0);
      chk("post_rst_rvalid", 64'(rd_out_valid), 64'd0);
    end

    // Randomized traffic, with one reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      fill_valid = NUM_REQ'($urandom_range(0, 3));
      fill_sid   = (NUM_REQ * SW)'($urandom);
      fill_qty   = {$urandom, $urandom};
      fill_side  = NUM_REQ'($urandom_range(0, 3));
      rd_valid   = ($urandom_range(0, 9) < 7);
      rd_sid     = SW'($urandom_range(0, 3));
      if (n == 1500) rst_n = 1'b0;
      if (n == 1502) rst_n = 1'b1;
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
